pll_lock_supervisor: RTL and testbench

//  Parametrised PLL bring-up and lock supervisor; sits beside the PLL core on refclk.
//  - Drives the PLL reset pulse.
//  - Filters the PLL locked flag.
//  - Releases NUM_CH downstream domain resets in staggered order.
//  - Detects loss of lock and retries acquisition, up to a bounded retry count.

---
 rtl/pll_lock_supervisor.sv | 212 +++++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: PLL reset pulse, lock filter, staggered channel release and bounded retry.
// Optional saturating loss-of-lock counter on loss_cnt_o when PLL_SUP_LOSS_CNT_EN is defined.
module pll_lock_supervisor #(
    parameter int NUM_CH           = 4,
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_FILTER_CYC  = 64,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int STAGGER_CYC      = 8,
    parameter int MAX_RETRY        = 3
) (
    input  logic              refclk_i,
    input  logic              rst_i,
    input  logic              pll_locked_i,
    input  logic              retry_req_i,
    output logic              pll_rst_o,
    output logic [NUM_CH-1:0] chan_rst_o,
    output logic              ready_o,
    output logic              fail_o,
    output logic              lock_lost_o
`ifdef PLL_SUP_LOSS_CNT_EN
    ,
    output logic [7:0]        loss_cnt_o
`endif
);

    localparam int PW = $clog2(RST_PULSE_CYC + 1);
    localparam int AW = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int FW = $clog2(LOCK_FILTER_CYC + 1);
    localparam int SW = $clog2(STAGGER_CYC * NUM_CH + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYC - 1);
    localparam logic [AW-1:0] ACQ_LAST   = AW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILTER_CYC - 1);
    localparam logic [SW-1:0] STAG_LAST  = SW'(STAGGER_CYC * NUM_CH - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        S_PRST,
        S_WAIT,
        S_FILT,
        S_REL,
        S_RUN,
        S_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, locked_s_q;
    logic [PW-1:0]     pulse_q, pulse_d;
    logic [AW-1:0]     acq_q, acq_d;
    logic [FW-1:0]     filt_q, filt_d;
    logic [SW-1:0]     stag_q, stag_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic              pll_rst_q, pll_rst_d;
    logic [NUM_CH-1:0] chan_rst_q, chan_rst_d;
    logic              ready_q, ready_d;
    logic              fail_q, fail_d;
    logic              lock_lost_q, lock_lost_d;

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= pll_locked_i;
            locked_s_q <= sync1_q;
        end
    end

    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            state_q     <= S_PRST;
            pulse_q     <= '0;
            acq_q       <= '0;
            filt_q      <= '0;
            stag_q      <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            chan_rst_q  <= '1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            acq_q       <= acq_d;
            filt_q      <= filt_d;
            stag_q      <= stag_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            chan_rst_q  <= chan_rst_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    // Outputs are computed one edge ahead so every port comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        pulse_d     = pulse_q;
        acq_d       = acq_q;
        filt_d      = filt_q;
        stag_d      = stag_q;
        retry_d     = retry_q;
        pll_rst_d   = pll_rst_q;
        chan_rst_d  = chan_rst_q;
        ready_d     = ready_q;
        fail_d      = fail_q;
        lock_lost_d = 1'b0;

        unique case (state_q)
            S_PRST: begin
                if (pulse_q == PULSE_LAST) begin
                    state_d   = S_WAIT;
                    pll_rst_d = 1'b0;
                    acq_d     = '0;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end
            S_WAIT, S_FILT: begin
                // Timeout wins over a filter pass landing on the same cycle.
                if (acq_q == ACQ_LAST) begin
                    retry_d = retry_q + 1'b1;
                    if (retry_q == RETRY_LAST) begin
                        state_d   = S_FAIL;
                        fail_d    = 1'b1;
                        pll_rst_d = 1'b0;
                    end else begin
                        state_d   = S_PRST;
                        pll_rst_d = 1'b1;
                        pulse_d   = '0;
                    end
                end else begin
                    acq_d = acq_q + 1'b1;
                    if (state_q == S_WAIT) begin
                        if (locked_s_q) begin
                            state_d = S_FILT;
                            filt_d  = '0;
                        end
                    end else if (!locked_s_q) begin
                        state_d = S_WAIT;
                    end else if (filt_q == FILT_LAST) begin
                        state_d = S_REL;
                        stag_d  = '0;
                    end else begin
                        filt_d = filt_q + 1'b1;
                    end
                end
            end
            S_REL: begin
                if (locked_s_q) begin
                    stag_d = stag_q + 1'b1;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (stag_q == SW'(STAGGER_CYC * (i + 1) - 1)) chan_rst_d[i] = 1'b0;
                    end
                    if (stag_q == STAG_LAST) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                        retry_d = '0;
                    end
                end
            end
            S_RUN: ;
            S_FAIL: begin
                chan_rst_d = '1;
                pll_rst_d  = 1'b0;
                if (retry_req_i) begin
                    state_d   = S_PRST;
                    fail_d    = 1'b0;
                    retry_d   = '0;
                    pll_rst_d = 1'b1;
                    pulse_d   = '0;
                end
            end
            default: state_d = S_PRST;
        endcase

        if ((state_q == S_REL || state_q == S_RUN) && !locked_s_q) begin
            state_d     = S_PRST;
            pulse_d     = '0;
            pll_rst_d   = 1'b1;
            chan_rst_d  = '1;
            ready_d     = 1'b0;
            lock_lost_d = 1'b1;
            retry_d     = '0;
        end
    end

    assign pll_rst_o   = pll_rst_q;
    assign chan_rst_o  = chan_rst_q;
    assign ready_o     = ready_q;
    assign fail_o      = fail_q;
    assign lock_lost_o = lock_lost_q;

`ifdef PLL_SUP_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            loss_cnt_q <= '0;
        end else if (lock_lost_d && loss_cnt_q != 8'hFF) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign loss_cnt_o = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters; cycle k = negedge after the k-th posedge following reset release.
// Loss counter section runs only when PLL_SUP_LOSS_CNT_EN is defined.
module tb_pll_lock_supervisor;

    localparam int NUM_CH = 3;

    logic              refclk = 1'b0;
    logic              rst = 1'b1;
    logic              pllLocked = 1'b0;
    logic              retryReq = 1'b0;
    logic              pllRst;
    logic [NUM_CH-1:0] chanRst;
    logic              ready;
    logic              fail;
    logic              lockLost;
`ifdef PLL_SUP_LOSS_CNT_EN
    logic [7:0]        lossCnt;
`endif

    int cyc = 0;
    int nCompared = 0;
    int nMismatched = 0;

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .NUM_CH(NUM_CH), .RST_PULSE_CYC(4), .LOCK_FILTER_CYC(8),
        .LOCK_TIMEOUT_CYC(32), .STAGGER_CYC(2), .MAX_RETRY(2)
    ) dut (
        .refclk_i    (refclk),
        .rst_i       (rst),
        .pll_locked_i(pllLocked),
        .retry_req_i (retryReq),
        .pll_rst_o   (pllRst),
        .chan_rst_o  (chanRst),
        .ready_o     (ready),
        .fail_o      (fail),
        .lock_lost_o (lockLost)
`ifdef PLL_SUP_LOSS_CNT_EN
        ,
        .loss_cnt_o  (lossCnt)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic toCycle(input int target);
        while (cyc < target) begin
            @(negedge refclk);
            cyc++;
        end
    endtask

    task automatic applyStimulus(input logic rstV, input logic lockV, input logic reqV);
        rst       = rstV;
        pllLocked = lockV;
        retryReq  = reqV;
    endtask

    // Holds reset across two edges and releases it; the next posedge is cycle 1.
    task automatic applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef PLL_SUP_LOSS_CNT_EN
        int waitCnt;
        int timeouts;
`endif
        // Reset values
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge refclk);
        checkOutput("rst_pll_rst", 32'(pllRst), 32'd1);
        checkOutput("rst_chan_rst", 32'(chanRst), 32'b111);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_fail", 32'(fail), 32'd0);
        checkOutput("rst_lock_lost", 32'(lockLost), 32'd0);

        // 1: clean lock
        rst = 1'b0;
        cyc = 0;
        toCycle(3);
        checkOutput("t1_pll_rst_hi", 32'(pllRst), 32'd1);
        toCycle(4);
        checkOutput("t1_pll_rst_lo", 32'(pllRst), 32'd0);
        toCycle(9);
        pllLocked = 1'b1;
        toCycle(21);
        checkOutput("t1_chan_c21", 32'(chanRst), 32'b111);
        toCycle(22);
        checkOutput("t1_chan_c22", 32'(chanRst), 32'b110);
        toCycle(24);
        checkOutput("t1_chan_c24", 32'(chanRst), 32'b100);
        toCycle(25);
        checkOutput("t1_ready_c25", 32'(ready), 32'd0);
        toCycle(26);
        checkOutput("t1_chan_c26", 32'(chanRst), 32'b000);
        checkOutput("t1_ready_c26", 32'(ready), 32'd1);
        toCycle(30);
        retryReq = 1'b1;
        toCycle(31);
        retryReq = 1'b0;
        checkOutput("t1_req_ignored_ready", 32'(ready), 32'd1);
        checkOutput("t1_req_ignored_pll", 32'(pllRst), 32'd0);

        // 2: one-cycle glitch three cycles into FILT
        applyReset();
        toCycle(9);
        pllLocked = 1'b1;
        toCycle(13);
        pllLocked = 1'b0;
        toCycle(14);
        pllLocked = 1'b1;
        toCycle(26);
        checkOutput("t2_chan_c26", 32'(chanRst), 32'b111);
        toCycle(27);
        checkOutput("t2_chan_c27", 32'(chanRst), 32'b110);
        toCycle(30);
        checkOutput("t2_ready_c30", 32'(ready), 32'd0);
        toCycle(31);
        checkOutput("t2_chan_c31", 32'(chanRst), 32'b000);
        checkOutput("t2_ready_c31", 32'(ready), 32'd1);

        // 3: never locks, two attempts then FAIL, then retry_req
        applyReset();
        toCycle(35);
        checkOutput("t3_pll_rst_c35", 32'(pllRst), 32'd0);
        toCycle(36);
        checkOutput("t3_pll_rst_c36", 32'(pllRst), 32'd1);
        toCycle(39);
        checkOutput("t3_pll_rst_c39", 32'(pllRst), 32'd1);
        toCycle(40);
        checkOutput("t3_pll_rst_c40", 32'(pllRst), 32'd0);
        toCycle(71);
        checkOutput("t3_fail_c71", 32'(fail), 32'd0);
        toCycle(72);
        checkOutput("t3_fail_c72", 32'(fail), 32'd1);
        checkOutput("t3_pll_rst_c72", 32'(pllRst), 32'd0);
        toCycle(80);
        checkOutput("t3_fail_c80", 32'(fail), 32'd1);
        checkOutput("t3_chan_c80", 32'(chanRst), 32'b111);
        retryReq = 1'b1;
        toCycle(81);
        retryReq = 1'b0;
        checkOutput("t3_retry_pll_rst", 32'(pllRst), 32'd1);
        checkOutput("t3_retry_fail", 32'(fail), 32'd0);
        toCycle(152);
        checkOutput("t3_fail_c152", 32'(fail), 32'd0);
        toCycle(153);
        checkOutput("t3_fail_c153", 32'(fail), 32'd1);

        // 4: loss of lock in RUN, then full relock
        applyReset();
        toCycle(9);
        pllLocked = 1'b1;
        toCycle(30);
        pllLocked = 1'b0;
        toCycle(32);
        checkOutput("t4_chan_c32", 32'(chanRst), 32'b000);
        checkOutput("t4_ready_c32", 32'(ready), 32'd1);
        toCycle(33);
        checkOutput("t4_chan_c33", 32'(chanRst), 32'b111);
        checkOutput("t4_ready_c33", 32'(ready), 32'd0);
        checkOutput("t4_lock_lost_c33", 32'(lockLost), 32'd1);
        checkOutput("t4_pll_rst_c33", 32'(pllRst), 32'd1);
        toCycle(34);
        pllLocked = 1'b1;
        checkOutput("t4_lock_lost_c34", 32'(lockLost), 32'd0);
        toCycle(37);
        checkOutput("t4_pll_rst_c37", 32'(pllRst), 32'd0);
        toCycle(51);
        checkOutput("t4_chan_c51", 32'(chanRst), 32'b100);
        toCycle(52);
        checkOutput("t4_chan_c52", 32'(chanRst), 32'b000);
        checkOutput("t4_ready_c52", 32'(ready), 32'd1);

        // 5: rst asserted in the middle of REL
        applyReset();
        toCycle(9);
        pllLocked = 1'b1;
        toCycle(22);
        checkOutput("t5_chan_c22", 32'(chanRst), 32'b110);
        rst = 1'b1;
        toCycle(23);
        checkOutput("t5_chan_after_rst", 32'(chanRst), 32'b111);
        checkOutput("t5_pll_rst_after_rst", 32'(pllRst), 32'd1);
        rst = 1'b0;
        cyc = 0;
        toCycle(3);
        checkOutput("t5_prst_c3", 32'(pllRst), 32'd1);
        toCycle(4);
        checkOutput("t5_prst_c4", 32'(pllRst), 32'd0);

`ifdef PLL_SUP_LOSS_CNT_EN
        // 6: loss counter saturation and clear
        applyReset();
        pllLocked = 1'b1;
        timeouts = 0;
        for (int ev = 0; ev < 300; ev++) begin
            waitCnt = 0;
            while (!ready && waitCnt < 200) begin
                @(negedge refclk);
                waitCnt++;
            end
            if (!ready) timeouts++;
            pllLocked = 1'b0;
            waitCnt = 0;
            while (!lockLost && waitCnt < 20) begin
                @(negedge refclk);
                waitCnt++;
            end
            if (!lockLost) timeouts++;
            pllLocked = 1'b1;
            if (ev == 9) checkOutput("t6_cnt_10", 32'(lossCnt), 32'd10);
        end
        checkOutput("t6_wait_timeouts", 32'(timeouts), 32'd0);
        checkOutput("t6_cnt_sat", 32'(lossCnt), 32'd255);
        applyReset();
        checkOutput("t6_cnt_rst", 32'(lossCnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
